// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
//   Parametrised up/down counter with run-time direction, count enable,
//   synchronous parallel load (clamped to MAX_VAL) and a programmable modulus.
//   It has a combinational terminal-count flag for cascading and a registered
//   wrap pulse.
//
//   Build option: COUNTER_SATURATE_EN
//     undefined (default) - count wraps around at the terminal value.
//     defined             - count holds at the terminal value. ovf pulses on
//                           each blocked step.
//
// Parameters
//   WIDTH     counter width in bits (1..32)
//   MAX_VAL   highest count value (1..2**WIDTH-1). It is used truncated to WIDTH.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-high reset
//   en        in   1      count enable
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      synchronous parallel load strobe
//   load_val  in   WIDTH  value to load (clamped to MAX_VAL)
//   count     out  WIDTH  registered count
//   tc        out  1      combinational: the next enabled step wraps/saturates
//   ovf       out  1      registered one-cycle pulse after a wrap/blocked step
// -----------------------------------------------------------------------------
module updown_counter #(
   parameter int unsigned      WIDTH   = 4,
   parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] r_count;
   logic             r_ovf;

   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_step_val;
   logic             w_step_ovf;
   logic             w_at_term;

   // The terminal value depends on the current direction.
   assign w_at_term      = up_dn ? (r_count == MAX_W) : (r_count == '0);
   assign w_load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

   // Value and ovf produced by one enabled step.
   always_comb begin
      w_step_val = r_count;
      w_step_ovf = 1'b0;
      if (w_at_term) begin
         w_step_ovf = 1'b1;
`ifdef COUNTER_SATURATE_EN
         w_step_val = r_count;
`else
         w_step_val = up_dn ? '0 : MAX_W;
`endif
      end else if (up_dn) begin
         w_step_val = r_count + WIDTH'(1);
      end else begin
         w_step_val = r_count - WIDTH'(1);
      end
   end

   // Count and ovf registers. Priority: reset > load > en > hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= up_dn ? '0 : MAX_W;
         r_ovf   <= 1'b0;
      end else if (load) begin
         r_count <= w_load_clamped;
         r_ovf   <= 1'b0;
      end else if (en) begin
         r_count <= w_step_val;
         r_ovf   <= w_step_ovf;
      end else begin
         r_ovf   <= 1'b0;
      end
   end

   assign count = r_count;
   assign ovf   = r_ovf;
   assign tc    = en & w_at_term;

endmodule
